// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift-register family.
//   drain_state_t : IDLE / DRAIN state of the draining shift register
//   clamp_count   : limits a requested entry count to the physical length
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Requested counts beyond the register length are treated as a full load.
    function automatic int unsigned clamp_count(input int unsigned cnt,
                                                input int unsigned len);
        return (cnt > len) ? len : cnt;
    endfunction

endpackage

// File: rtl/RegEnXBit.sv
// Enabled register of WIDTH bits with synchronous active-high reset.
//   clk   : clock
//   reset : synchronous, active-high; clears q
//   en    : capture d on the next rising edge
//   d     : data in
//   q     : registered data out
module RegEnXBit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_right_drain_reg.sv
// Parallel-in, serial-out right-shift register with a valid/ready drain port.
// A batch of up to SHIFTERLEN entries is loaded in one cycle and presented
// one per cycle, entry 0 first.
//   clk, reset  : clock, synchronous active-high reset
//   load_valid  : producer offers a batch
//   load_ready  : a batch can be accepted this cycle
//   load_data   : batch entries, index 0 drains first
//   load_count  : number of valid entries (0 ignored, clamped to SHIFTERLEN)
//   out_valid   : out_data holds a valid entry
//   out_ready   : consumer accepts out_data
//   out_data    : head entry
//   remaining   : entries still to drain, including the head
//   busy        : high while draining
module shift_right_drain_reg
    import shift_reg_pkg::*;
#(
    parameter  int unsigned BITWIDTH   = 1,
    parameter  int unsigned SHIFTERLEN = 10,
    localparam int unsigned CNTW       = $clog2(SHIFTERLEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [BITWIDTH-1:0] load_data [SHIFTERLEN-1:0],
    input  logic [CNTW-1:0]     load_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [CNTW-1:0]     remaining,
    output logic                busy
);

    drain_state_t        state_q, state_d;
    logic [CNTW-1:0]     remaining_q, remaining_d;
    logic [CNTW-1:0]     count_clamped;
    logic                load_fire;
    logic                shift_fire;
    logic [BITWIDTH-1:0] entry [SHIFTERLEN-1:0];

    assign count_clamped = CNTW'(clamp_count(32'(load_count), SHIFTERLEN));

    // Handshake decode; a draining last entry frees the slot for a new batch.
    assign out_valid  = (state_q == DRAIN);
    assign busy       = (state_q == DRAIN);
    assign out_data   = entry[0];
    assign remaining  = remaining_q;
    assign load_ready = (state_q == IDLE) | ((remaining_q == CNTW'(1)) & out_ready);
    assign load_fire  = load_valid & load_ready & (load_count != '0);
    assign shift_fire = out_valid & out_ready;

    // Entry storage: load has priority over shift, vacated slots fill with 0.
    for (genvar i = 0; i < SHIFTERLEN; i++) begin : g_entry
        localparam logic [CNTW-1:0] IDX = CNTW'(i);
        logic [BITWIDTH-1:0] shift_in;
        logic [BITWIDTH-1:0] d;

        if (i == SHIFTERLEN - 1) begin : g_top
            assign shift_in = '0;
        end else begin : g_mid
            assign shift_in = entry[i+1];
        end

        assign d = load_fire ? ((IDX < count_clamped) ? load_data[i] : '0)
                             : shift_in;

        RegEnXBit #(
            .WIDTH (BITWIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (load_fire | shift_fire),
            .d     (d),
            .q     (entry[i])
        );
    end

    // State and remaining-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (load_fire) begin
            state_d     = DRAIN;
            remaining_d = count_clamped;
        end else if (shift_fire) begin
            remaining_d = remaining_q - CNTW'(1);
            if (remaining_q == CNTW'(1)) begin
                state_d = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_shift_right_drain_reg.sv
module tb_shift_right_drain_reg;

    localparam int unsigned BW  = 8;
    localparam int unsigned LEN = 4;
    localparam int unsigned CW  = 3;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [BW-1:0] load_data [LEN-1:0];
    logic [CW-1:0] load_count;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [CW-1:0] remaining;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: the queue of entries still to be delivered.
    logic [BW-1:0] model_q [$];

    shift_right_drain_reg #(
        .BITWIDTH   (BW),
        .SHIFTERLEN (LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_count (load_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .remaining  (remaining),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [13:0] obs = {out_valid, busy, out_data, remaining, load_ready};

    function automatic logic [13:0] exp_vec();
        logic          v;
        logic [BW-1:0] d;
        logic          lr;
        v  = (model_q.size() != 0);
        d  = v ? model_q[0] : 8'h00;
        lr = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
        return {v, v, d, 3'(model_q.size()), lr};
    endfunction

    // Clock the DUT one cycle and advance the model with the same inputs.
    task automatic advance();
        int   n;
        logic lr;
        logic fire;
        lr   = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
        fire = load_valid && lr && (load_count != 0);
        @(posedge clk);
        if (reset) begin
            model_q.delete();
        end else if (fire) begin
            n = (int'(load_count) > int'(LEN)) ? int'(LEN) : int'(load_count);
            model_q.delete();
            for (int i = 0; i < n; i++) model_q.push_back(load_data[i]);
        end else if (model_q.size() != 0 && out_ready) begin
            void'(model_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic set_batch(input logic [BW-1:0] a, input logic [BW-1:0] b,
                             input logic [BW-1:0] c, input logic [BW-1:0] d,
                             input logic [CW-1:0] cnt);
        load_data[0] = a;
        load_data[1] = b;
        load_data[2] = c;
        load_data[3] = d;
        load_count   = cnt;
        load_valid   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        advance();
        advance();
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_vec got=%h exp=%h", obs, exp_vec());
        end
        checks++;
        if ({out_valid, load_ready, remaining, out_data} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got v=%b lr=%b rem=%0d d=%h exp v=0 lr=1 rem=0 d=00",
                     out_valid, load_ready, remaining, out_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_drain();
        logic [BW-1:0] got [$];
        logic [BW-1:0] want [4];
        want = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        out_ready = 1'b1;
        set_batch(8'hA0, 8'hB1, 8'hC2, 8'hD3, 3'd4);
        #1;
        advance();
        load_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (out_valid) got.push_back(out_data);
            advance();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL full_drain_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL full_drain_seq idx=%0d got=%h exp=%h", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_batch(8'h11, 8'h22, 8'h99, 8'h99, 3'd2);
        #1;
        advance();
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({out_valid, out_data, remaining, load_ready} !== {1'b1, 8'h11, 3'd2, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h rem=%0d lr=%b exp v=1 d=11 rem=2 lr=0",
                         c, out_valid, out_data, remaining, load_ready);
            end
            advance();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stall_release cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] want [3];
        want = '{8'h01, 8'h02, 8'h03};
        out_ready = 1'b1;
        set_batch(8'h01, 8'h02, 8'h00, 8'h00, 3'd2);
        #1;
        advance();
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_batch(8'h03, 8'h55, 8'h66, 8'h77, 3'd1);
            #1;
            checks++;
            if ({out_valid, out_data} !== {1'b1, want[c]}) begin
                errors++;
                $display("FAIL b2b_seq cyc=%0d got v=%b d=%h exp v=1 d=%h",
                         c, out_valid, out_data, want[c]);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
            load_valid = 1'b0;
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got v=%b exp v=0", out_valid);
        end
    endtask

    task automatic test_illegal_counts();
        out_ready = 1'b1;
        set_batch(8'hEE, 8'hEE, 8'hEE, 8'hEE, 3'd0);
        #1;
        advance();
        load_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, remaining, load_ready} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL count_zero got v=%b rem=%0d lr=%b exp v=0 rem=0 lr=1",
                     out_valid, remaining, load_ready);
        end
        set_batch(8'h5A, 8'h6B, 8'h7C, 8'h8D, 3'd7);
        advance();
        load_valid = 1'b0;
        #1;
        checks++;
        if (remaining !== 3'd4) begin
            errors++;
            $display("FAIL count_clamp got rem=%0d exp rem=4", remaining);
        end
        for (int c = 0; c < 5; c++) begin
            if (c != 0) #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL count_clamp_drain cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        set_batch(8'hC1, 8'hC2, 8'hC3, 8'hC4, 3'd4);
        #1;
        advance();
        load_valid = 1'b0;
        advance();
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, remaining} !== {1'b1, 8'hC2, 3'd3}) begin
            errors++;
            $display("FAIL mid_reset_pre got v=%b d=%h rem=%0d exp v=1 d=c2 rem=3",
                     out_valid, out_data, remaining);
        end
        advance();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({out_valid, busy, out_data, remaining, load_ready} !==
                {1'b0, 1'b0, 8'h00, 3'd0, 1'b1}) begin
                errors++;
                $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, obs,
                         {1'b0, 1'b0, 8'h00, 3'd0, 1'b1});
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 39) == 0);
            load_valid   = ($urandom_range(0, 2) == 0);
            load_count   = CW'($urandom_range(0, 7));
            for (int i = 0; i < LEN; i++) load_data[i] = BW'($urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
        reset      = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_count = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < LEN; i++) load_data[i] = '0;
        @(negedge clk);
        test_reset();
        test_full_drain();
        test_stall();
        test_back_to_back();
        test_illegal_counts();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
